fx3_slave_fifo_responder: RTL and testbench

//  Synthesizable model of the FX3 side of the 32-bit, 2-bit-address GPIF slave-FIFO interface.

---
 rtl/fx3_gpif_pkg.sv | 32 +++
 rtl/sync_fifo_fwft.sv | 76 +++++++
 rtl/fx3_slave_fifo_responder.sv | 185 ++++++++++++++++++
 tb/tb_fx3_slave_fifo_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx3_gpif_pkg.sv
// Shared constants and types for the FX3 slave-FIFO responder model.
// Flag vectors are carried active-low, exactly as they appear on the pins.
package fx3_gpif_pkg;

    localparam int DATA_W       = 32;
    localparam int ZLP_W        = 16;
    localparam int RD_LAT_DEF   = 2;
    localparam int FLAG_LAT_DEF = 3;

    localparam logic [1:0] GPIF_RX_ADDR = 2'd0;
    localparam logic [1:0] GPIF_TX_ADDR = 2'd3;

    typedef struct packed {
        logic a_b;  // RX full
        logic b_b;  // RX free space at or below watermark
        logic c_b;  // TX empty
        logic d_b;  // TX occupancy at or below watermark
    } flags_t;

    localparam flags_t FLAGS_RST = '{a_b: 1'b1, b_b: 1'b1, c_b: 1'b0, d_b: 1'b0};

    function automatic flags_t make_flags(input logic rx_full, input logic rx_low_free,
                                          input logic tx_empty, input logic tx_low_occ);
        flags_t f;
        f.a_b = ~rx_full;
        f.b_b = ~rx_low_free;
        f.c_b = ~tx_empty;
        f.d_b = ~tx_low_occ;
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy outputs and a port
// that sets the top bit of the most recently written entry.
module sync_fifo_fwft #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    input  logic                  i_set_last,
    output logic [WIDTH-1:0]      o_data,
    output logic [WIDTH-1:0]      o_newest,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic [DEPTH_LOG2:0]   o_count_next,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [DEPTH_LOG2:0]   DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic [DEPTH_LOG2-1:0] w_newest_ptr;
    logic                  w_push;
    logic                  w_pop;

    assign o_full       = (r_count == DEPTH);
    assign o_empty      = (r_count == {(DEPTH_LOG2+1){1'b0}});
    assign w_push       = i_push & ~o_full;
    assign w_pop        = i_pop & ~o_empty;
    assign w_newest_ptr = r_wr_ptr - PTR_ONE;
    assign o_data       = r_mem[r_rd_ptr];
    assign o_newest     = r_mem[w_newest_ptr];
    assign o_count      = r_count;
    assign o_count_next = w_count_next;

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end else if (i_set_last & ~o_empty) begin
            r_mem[w_newest_ptr][WIDTH-1] <= 1'b1;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {DEPTH_LOG2{1'b0}};
            r_rd_ptr <= {DEPTH_LOG2{1'b0}};
            r_count  <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/fx3_slave_fifo_responder.sv
// FX3 side of the 32-bit slave-FIFO interface: pin decode, RX/TX buffers,
// delayed read data, delayed active-low flags, ZLP counting and sticky errors.
module fx3_slave_fifo_responder
    import fx3_gpif_pkg::*;
#(
    parameter int         DEPTH_LOG2 = 9,
    parameter int         WATERMARK  = 4,
    parameter int         RD_LAT     = RD_LAT_DEF,
    parameter int         FLAG_LAT   = FLAG_LAT_DEF,
    parameter logic [1:0] RX_ADDR    = GPIF_RX_ADDR,
    parameter logic [1:0] TX_ADDR    = GPIF_TX_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        faddr,
    input  logic [DATA_W-1:0] fdata_in,
    output logic [DATA_W-1:0] fdata_out,
    output logic              fdata_oe,
    input  logic              slcs_b,
    input  logic              slwr_b,
    input  logic              slrd_b,
    input  logic              sloe_b,
    input  logic              pktend_b,
    output logic              flaga_b,
    output logic              flagb_b,
    output logic              flagc_b,
    output logic              flagd_b,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_last,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [ZLP_W-1:0]  zlp_count,
    output logic              ovf_err,
    output logic              unf_err
);

    localparam logic [DEPTH_LOG2:0] DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] WM      = (DEPTH_LOG2+1)'(WATERMARK);
    localparam logic [ZLP_W-1:0]    ZLP_ONE = {{(ZLP_W-1){1'b0}}, 1'b1};

    logic                w_rx_sel, w_tx_sel;
    logic                w_rx_wr, w_pkt_only, w_tx_rd;
    logic                w_rx_host_pop, w_tx_host_push;
    logic                w_mark, w_zlp;
    logic [DATA_W:0]     w_rx_dout, w_rx_newest;
    logic [DEPTH_LOG2:0] w_rx_count, w_rx_count_next, w_rx_free_next;
    logic                w_rx_full, w_rx_empty;
    logic [DATA_W-1:0]   w_tx_dout, w_tx_newest_unused, w_rd_word;
    logic [DEPTH_LOG2:0] w_tx_count_unused, w_tx_count_next;
    logic                w_tx_full, w_tx_empty;
    flags_t              w_raw_flags;
    flags_t              r_flag_pipe [FLAG_LAT];
    logic [DATA_W-1:0]   r_fdata_out;
    logic [ZLP_W-1:0]    r_zlp_count;
    logic                r_ovf, r_unf;

    assign w_rx_sel   = ~slcs_b & (faddr == RX_ADDR);
    assign w_tx_sel   = ~slcs_b & (faddr == TX_ADDR);
    assign w_rx_wr    = w_rx_sel & ~slwr_b;
    assign w_pkt_only = w_rx_sel & slwr_b & ~pktend_b;
    assign w_tx_rd    = w_tx_sel & ~slrd_b;

    assign w_rx_host_pop  = ~w_rx_empty & rx_ready;
    assign w_tx_host_push = tx_valid & ~w_tx_full;

    // A lone pktend closes the newest word only if it is open and not leaving this cycle.
    assign w_mark = w_pkt_only & ~w_rx_empty & ~w_rx_newest[DATA_W]
                  & ~(w_rx_host_pop & (w_rx_count == CNT_ONE));
    assign w_zlp  = w_pkt_only & ~w_mark;

    assign w_rd_word = w_tx_empty ? {DATA_W{1'b0}} : w_tx_dout;

    sync_fifo_fwft #(.WIDTH(DATA_W + 1), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_rx_wr),
        .i_data       ({~pktend_b, fdata_in}),
        .i_pop        (w_rx_host_pop),
        .i_set_last   (w_mark),
        .o_data       (w_rx_dout),
        .o_newest     (w_rx_newest),
        .o_count      (w_rx_count),
        .o_count_next (w_rx_count_next),
        .o_full       (w_rx_full),
        .o_empty      (w_rx_empty)
    );

    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_tx_host_push),
        .i_data       (tx_data),
        .i_pop        (w_tx_rd),
        .i_set_last   (1'b0),
        .o_data       (w_tx_dout),
        .o_newest     (w_tx_newest_unused),
        .o_count      (w_tx_count_unused),
        .o_count_next (w_tx_count_next),
        .o_full       (w_tx_full),
        .o_empty      (w_tx_empty)
    );

    // Read pipeline: RD_LAT-1 shift stages feeding a hold register on fdata_out.
    logic [RD_LAT-1:0] w_chain_vld;
    logic [DATA_W-1:0] w_chain_dat [RD_LAT];

    assign w_chain_vld[0] = w_tx_rd;
    assign w_chain_dat[0] = w_rd_word;

    for (genvar i = 1; i < RD_LAT; i++) begin : g_rd_stage
        logic              r_vld;
        logic [DATA_W-1:0] r_dat;

        // One cycle of read latency.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_vld <= 1'b0;
                r_dat <= {DATA_W{1'b0}};
            end else begin
                r_vld <= w_chain_vld[i-1];
                r_dat <= w_chain_dat[i-1];
            end
        end

        assign w_chain_vld[i] = r_vld;
        assign w_chain_dat[i] = r_dat;
    end

    // Final read stage holds the last word until another emerges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fdata_out <= {DATA_W{1'b0}};
        end else if (w_chain_vld[RD_LAT-1]) begin
            r_fdata_out <= w_chain_dat[RD_LAT-1];
        end
    end

    assign w_rx_free_next = DEPTH - w_rx_count_next;
    assign w_raw_flags = make_flags(w_rx_count_next == DEPTH,
                                    w_rx_free_next <= WM,
                                    w_tx_count_next == {(DEPTH_LOG2+1){1'b0}},
                                    w_tx_count_next <= WM);

    // Flag delay line; the last entry is the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FLAG_LAT; i++) r_flag_pipe[i] <= FLAGS_RST;
        end else begin
            r_flag_pipe[0] <= w_raw_flags;
            for (int i = 1; i < FLAG_LAT; i++) r_flag_pipe[i] <= r_flag_pipe[i-1];
        end
    end

    // Sticky errors and the wrapping ZLP counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_zlp_count <= {ZLP_W{1'b0}};
        end else begin
            if (w_rx_wr & w_rx_full)  r_ovf <= 1'b1;
            if (w_tx_rd & w_tx_empty) r_unf <= 1'b1;
            if (w_zlp)                r_zlp_count <= r_zlp_count + ZLP_ONE;
        end
    end

    assign fdata_out = r_fdata_out;
    assign fdata_oe  = w_tx_sel & ~sloe_b;
    assign flaga_b   = r_flag_pipe[FLAG_LAT-1].a_b;
    assign flagb_b   = r_flag_pipe[FLAG_LAT-1].b_b;
    assign flagc_b   = r_flag_pipe[FLAG_LAT-1].c_b;
    assign flagd_b   = r_flag_pipe[FLAG_LAT-1].d_b;
    assign rx_data   = w_rx_dout[DATA_W-1:0];
    assign rx_last   = w_rx_dout[DATA_W];
    assign rx_valid  = ~w_rx_empty;
    assign tx_ready  = ~w_tx_full;
    assign zlp_count = r_zlp_count;
    assign ovf_err   = r_ovf;
    assign unf_err   = r_unf;

endmodule

// File: tb/tb_fx3_slave_fifo_responder.sv
// Bench for fx3_slave_fifo_responder: queue-based reference model checked every
// cycle, a decode table, directed corner sequences and a randomized phase.
module tb_fx3_slave_fifo_responder;

    localparam int DEPTH    = 512;
    localparam int WM       = 4;
    localparam int RD_LAT   = 2;
    localparam int FLAG_LAT = 3;

    logic        clk;
    logic        reset;
    logic [1:0]  faddr;
    logic [31:0] fdata_in, fdata_out, rx_data, tx_data;
    logic        fdata_oe, slcs_b, slwr_b, slrd_b, sloe_b, pktend_b;
    logic        flaga_b, flagb_b, flagc_b, flagd_b;
    logic        rx_last, rx_valid, rx_ready, tx_valid, tx_ready, ovf_err, unf_err;
    logic [15:0] zlp_count;

    fx3_slave_fifo_responder dut (
        .clk(clk), .reset(reset), .faddr(faddr), .fdata_in(fdata_in),
        .fdata_out(fdata_out), .fdata_oe(fdata_oe), .slcs_b(slcs_b), .slwr_b(slwr_b),
        .slrd_b(slrd_b), .sloe_b(sloe_b), .pktend_b(pktend_b),
        .flaga_b(flaga_b), .flagb_b(flagb_b), .flagc_b(flagc_b), .flagd_b(flagd_b),
        .rx_data(rx_data), .rx_last(rx_last), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .zlp_count(zlp_count), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: buffers as queues, latencies as timed event lists.
    typedef struct { int due; logic [31:0] d; } rd_ev_t;
    typedef struct { int due; logic [3:0]  f; } fl_ev_t;
    logic [32:0] m_rxq[$];
    logic [31:0] m_txq[$];
    rd_ev_t      m_rd_ev[$];
    fl_ev_t      m_fl_ev[$];
    logic [15:0] m_zlp;
    logic        m_ovf, m_unf;
    logic [31:0] m_fdata;
    logic [3:0]  m_flags;
    int          cyc = 0;

    typedef struct {
        logic       slcs_b, sloe_b, slwr_b;
        logic [1:0] faddr;
        logic       exp_oe, exp_push;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        slcs_b = 1'b1; slwr_b = 1'b1; slrd_b = 1'b1; sloe_b = 1'b1; pktend_b = 1'b1;
        faddr = 2'd0; fdata_in = 32'h0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 32'h0;
    endtask

    task automatic model_reset();
        m_rxq.delete(); m_txq.delete(); m_rd_ev.delete(); m_fl_ev.delete();
        m_zlp = 16'h0; m_ovf = 1'b0; m_unf = 1'b0; m_fdata = 32'h0; m_flags = 4'b1100;
    endtask

    // Apply the behavioural rules for one clock edge using the sampled pins.
    task automatic model_edge();
        bit          rxs, txs, host_pop, host_push;
        int          rxn, txn;
        logic [31:0] w;
        rxs = !slcs_b && faddr == 2'd0;
        txs = !slcs_b && faddr == 2'd3;
        rxn = m_rxq.size();
        txn = m_txq.size();
        host_pop  = rxn > 0 && rx_ready;
        host_push = txn < DEPTH && tx_valid;
        if (rxs && !slwr_b) begin
            if (rxn < DEPTH) m_rxq.push_back({!pktend_b, fdata_in});
            else m_ovf = 1'b1;
        end else if (rxs && !pktend_b) begin
            if (rxn > 0 && !m_rxq[rxn-1][32] && !(host_pop && rxn == 1)) m_rxq[rxn-1][32] = 1'b1;
            else m_zlp = m_zlp + 16'd1;
        end
        if (host_pop) void'(m_rxq.pop_front());
        w = 32'h0;
        if (txs && !slrd_b) begin
            if (txn > 0) w = m_txq.pop_front();
            else m_unf = 1'b1;
            m_rd_ev.push_back('{due: cyc + RD_LAT - 1, d: w});
        end
        if (host_push) m_txq.push_back(tx_data);
        m_fl_ev.push_back('{due: cyc + FLAG_LAT - 1,
                            f: {m_rxq.size() != DEPTH, (DEPTH - m_rxq.size()) > WM,
                                m_txq.size() != 0, m_txq.size() > WM}});
        while (m_rd_ev.size() > 0 && m_rd_ev[0].due <= cyc) m_fdata = m_rd_ev.pop_front().d;
        while (m_fl_ev.size() > 0 && m_fl_ev[0].due <= cyc) m_flags = m_fl_ev.pop_front().f;
        cyc++;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".fdata_out"}, fdata_out, m_fdata);
        chk({tag, ".fdata_oe"}, fdata_oe, !slcs_b && faddr == 2'd3 && !sloe_b);
        chk({tag, ".flags"}, {flaga_b, flagb_b, flagc_b, flagd_b}, m_flags);
        chk({tag, ".rx_valid"}, rx_valid, m_rxq.size() > 0);
        chk({tag, ".tx_ready"}, tx_ready, m_txq.size() < DEPTH);
        if (m_rxq.size() > 0) chk({tag, ".rx_word"}, {rx_last, rx_data}, m_rxq[0]);
        chk({tag, ".zlp"}, zlp_count, m_zlp);
        chk({tag, ".errs"}, {ovf_err, unf_err}, {m_ovf, m_unf});
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        set_idle();
        #2 reset = 1'b1;
        model_reset();
        #1 check_outputs("rst_async");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_outputs("rst_rel");
    endtask

    initial begin
        tbl[0] = '{slcs_b: 1'b0, sloe_b: 1'b0, slwr_b: 1'b0, faddr: 2'd3, exp_oe: 1'b1, exp_push: 1'b0};
        tbl[1] = '{slcs_b: 1'b0, sloe_b: 1'b1, slwr_b: 1'b0, faddr: 2'd0, exp_oe: 1'b0, exp_push: 1'b1};
        tbl[2] = '{slcs_b: 1'b1, sloe_b: 1'b0, slwr_b: 1'b0, faddr: 2'd0, exp_oe: 1'b0, exp_push: 1'b0};
        tbl[3] = '{slcs_b: 1'b1, sloe_b: 1'b0, slwr_b: 1'b0, faddr: 2'd3, exp_oe: 1'b0, exp_push: 1'b0};
        tbl[4] = '{slcs_b: 1'b0, sloe_b: 1'b0, slwr_b: 1'b0, faddr: 2'd1, exp_oe: 1'b0, exp_push: 1'b0};
        tbl[5] = '{slcs_b: 1'b0, sloe_b: 1'b0, slwr_b: 1'b0, faddr: 2'd2, exp_oe: 1'b0, exp_push: 1'b0};
        tbl[6] = '{slcs_b: 1'b0, sloe_b: 1'b0, slwr_b: 1'b1, faddr: 2'd0, exp_oe: 1'b0, exp_push: 1'b0};
        tbl[7] = '{slcs_b: 1'b0, sloe_b: 1'b0, slwr_b: 1'b0, faddr: 2'd0, exp_oe: 1'b0, exp_push: 1'b1};

        reset = 1'b1;
        set_idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Pin decode table.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            slcs_b = tbl[i].slcs_b; sloe_b = tbl[i].sloe_b; slwr_b = tbl[i].slwr_b;
            faddr = tbl[i].faddr; fdata_in = 32'hC0DE_0000 + 32'(i);
            #1 chk($sformatf("tbl%0d.oe", i), fdata_oe, tbl[i].exp_oe);
            cycle("tbl");
            chk($sformatf("tbl%0d.push", i), rx_valid, tbl[i].exp_push);
        end

        // Host fills TX with 8 words, FPGA reads them back.
        do_reset();
        tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_data = 32'h100 + 32'(i);
            cycle("t1_fill");
        end
        set_idle();
        for (int i = 0; i < FLAG_LAT; i++) cycle("t1_idle");
        chk("t1.flagc_full", flagc_b, 1'b1);
        slcs_b = 1'b0; faddr = 2'd3; sloe_b = 1'b0;
        for (int j = 0; j < 12; j++) begin
            slrd_b = (j < 8) ? 1'b0 : 1'b1;
            cycle("t1_read");
            if (j == 0) chk("t1.fdata_pre", fdata_out, 32'h0);
            if (j >= RD_LAT - 1 && j < 8 + RD_LAT - 1)
                chk($sformatf("t1.word%0d", j - RD_LAT + 1), fdata_out, 32'h100 + 32'(j - RD_LAT + 1));
            if (j == 8) chk("t1.flagc_hold", flagc_b, 1'b1);
            if (j == 9) chk("t1.flagc_fall", flagc_b, 1'b0);
        end

        // Read while TX is empty.
        slrd_b = 1'b0;
        cycle("t4_rd");
        slrd_b = 1'b1;
        chk("t4.unf", unf_err, 1'b1);
        chk("t4.fdata_hold", fdata_out, 32'h107);
        cycle("t4_wait");
        chk("t4.fdata_zero", fdata_out, 32'h0);
        chk("t4.tx_ready", tx_ready, 1'b1);

        // Fill RX to overflow, then drain.
        do_reset();
        slcs_b = 1'b0; faddr = 2'd0; slwr_b = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            fdata_in = 32'h2000 + 32'(i);
            cycle("t2_wr");
            if (i == DEPTH - 1) chk("t2.no_ovf", ovf_err, 1'b0);
            if (i == DEPTH) chk("t2.flaga_hold", flaga_b, 1'b1);
        end
        chk("t2.ovf", ovf_err, 1'b1);
        set_idle();
        cycle("t2_idle");
        chk("t2.flaga_fall", flaga_b, 1'b0);
        rx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2.drain", {rx_valid, rx_data}, {1'b1, 32'h2000 + 32'(i)});
            cycle("t2_rd");
        end
        chk("t2.empty", rx_valid, 1'b0);

        // Packet of 5 then a zero-length packet.
        do_reset();
        slcs_b = 1'b0; faddr = 2'd0; slwr_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fdata_in = 32'hA0 + 32'(i);
            pktend_b = (i == 4) ? 1'b0 : 1'b1;
            cycle("t3_wr");
        end
        slwr_b = 1'b1; pktend_b = 1'b0;
        cycle("t3_zlp");
        chk("t3.zlp", zlp_count, 16'd1);
        set_idle();
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3.last%0d", i), {rx_last, rx_data}, {(i == 4), 32'hA0 + 32'(i)});
            cycle("t3_rd");
        end

        // Same-cycle host push and FPGA pop at occupancy 1.
        do_reset();
        tx_valid = 1'b1; tx_data = 32'h55;
        cycle("t5_push");
        set_idle();
        for (int i = 0; i < FLAG_LAT; i++) cycle("t5_idle");
        chk("t5.flagc_pre", flagc_b, 1'b1);
        tx_valid = 1'b1; tx_data = 32'h66;
        slcs_b = 1'b0; faddr = 2'd3; sloe_b = 1'b0; slrd_b = 1'b0;
        cycle("t5_both");
        set_idle();
        for (int i = 0; i < FLAG_LAT + 2; i++) begin
            cycle("t5_hold");
            chk("t5.flagc", flagc_b, 1'b1);
        end
        chk("t5.word", fdata_out, 32'h55);

        // Reset with RX loaded and a read in flight.
        do_reset();
        tx_valid = 1'b1; tx_data = 32'h77;
        cycle("t6_tx");
        set_idle();
        slcs_b = 1'b0; faddr = 2'd0; slwr_b = 1'b0;
        for (int i = 0; i < 100; i++) begin
            fdata_in = 32'h3000 + 32'(i);
            cycle("t6_wr");
        end
        slwr_b = 1'b1; faddr = 2'd3; slrd_b = 1'b0;
        cycle("t6_rd");
        do_reset();
        chk("t6.rx_valid", rx_valid, 1'b0);
        chk("t6.fdata", fdata_out, 32'h0);
        slcs_b = 1'b0; faddr = 2'd3; slrd_b = 1'b0;
        cycle("t6_post");
        chk("t6.unf", unf_err, 1'b1);

        // Randomized traffic: first fill-biased, then drain-biased.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 5);
            slcs_b   = ($urandom_range(0, 7) == 0);
            faddr    = (r < 3) ? 2'd0 : (r < 5) ? 2'd3 : 2'd1;
            slwr_b   = ($urandom_range(0, 2) == 0);
            slrd_b   = ($urandom_range(0, 2) == 0);
            sloe_b   = ($urandom_range(0, 1) == 0);
            pktend_b = ($urandom_range(0, 5) != 0);
            fdata_in = $urandom;
            tx_data  = $urandom;
            tx_valid = ($urandom_range(0, 1) == 0);
            rx_ready = (i < 1500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
